// File: rtl/alu_share_arbiter_if.sv
// Request/response and ALU operand bundle shared between the two ALU
// requesters, the arbiter and the ALU itself.
interface alu_share_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 6
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_src1;
  logic [DATA_W-1:0] req0_src2;
  logic [DATA_W-1:0] req0_imm;
  logic [CTRL_W-1:0] req0_ctrl;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_src1;
  logic [DATA_W-1:0] req1_src2;
  logic [DATA_W-1:0] req1_imm;
  logic [CTRL_W-1:0] req1_ctrl;

  logic              rsp0_valid;
  logic              rsp0_ready;
  logic [DATA_W-1:0] rsp0_result;
  logic              rsp0_err;

  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp1_result;
  logic              rsp1_err;

  logic [DATA_W-1:0] alu_src1;
  logic [DATA_W-1:0] alu_src2;
  logic [DATA_W-1:0] alu_imm;
  logic [CTRL_W-1:0] alu_control;
  logic [DATA_W-1:0] alu_result;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_src1, req0_src2, req0_imm, req0_ctrl,
    input  req1_valid, req1_src1, req1_src2, req1_imm, req1_ctrl,
    input  rsp0_ready, rsp1_ready, alu_result,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result, rsp0_err,
    output rsp1_valid, rsp1_result, rsp1_err,
    output alu_src1, alu_src2, alu_imm, alu_control
  );

  // Requester/ALU side
  modport master (
    output req0_valid, req0_src1, req0_src2, req0_imm, req0_ctrl,
    output req1_valid, req1_src1, req1_src2, req1_imm, req1_ctrl,
    output rsp0_ready, rsp1_ready, alu_result,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_result, rsp0_err,
    input  rsp1_valid, rsp1_result, rsp1_err,
    input  alu_src1, alu_src2, alu_imm, alu_control
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between the execute stage
// (port 0) and the address/branch helper (port 1).
//
// state | meaning
// IDLE  | arbitrate between valid requests, accept the winner
// EXEC  | operands on the ALU for one cycle, result captured at exit
// RESP  | owner's response valid, held until rsp_ready
module alu_share_arbiter #(
  parameter int                DATA_W = 32,
  parameter int                CTRL_W = 6,
  parameter logic [CTRL_W-1:0] MAX_OP = 6'h11
) (
  input logic               clk,
  input logic               rst_n,
  alu_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t            state_q, state_d;
  logic              last_grant_q;
  logic              owner_q;
  logic              grant0, grant1, sel, legal;
  logic              accept, rsp_fire;
  logic              req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [DATA_W-1:0] sel_src1, sel_src2, sel_imm;
  logic [CTRL_W-1:0] sel_ctrl;
  logic [DATA_W-1:0] alu_src1_q, alu_src2_q, alu_imm_q;
  logic [CTRL_W-1:0] alu_control_q;
  logic [DATA_W-1:0] result0_q, result1_q;
  logic              err0_q, err1_q;

  // Round-robin winner and its payload; a tie goes to the port not granted last
  always_comb begin
    grant0   = bus.req0_valid && (!bus.req1_valid || last_grant_q);
    grant1   = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
    sel      = grant1;
    sel_src1 = sel ? bus.req1_src1 : bus.req0_src1;
    sel_src2 = sel ? bus.req1_src2 : bus.req0_src2;
    sel_imm  = sel ? bus.req1_imm  : bus.req0_imm;
    sel_ctrl = sel ? bus.req1_ctrl : bus.req0_ctrl;
    legal    = (sel_ctrl != '0) && (sel_ctrl <= MAX_OP);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake outputs
  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    accept     = 1'b0;
    rsp_fire   = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready = grant0;
        req1_ready = grant1;
        accept     = grant0 || grant1;
        if (accept) state_d = legal ? EXEC : RESP;
      end
      EXEC: state_d = RESP;
      RESP: begin
        rsp0_valid = !owner_q;
        rsp1_valid = owner_q;
        rsp_fire   = owner_q ? bus.rsp1_ready : bus.rsp0_ready;
        if (rsp_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand, ownership and per-port result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q  <= 1'b1;
      owner_q       <= 1'b0;
      alu_src1_q    <= '0;
      alu_src2_q    <= '0;
      alu_imm_q     <= '0;
      alu_control_q <= '0;
      result0_q     <= '0;
      result1_q     <= '0;
      err0_q        <= 1'b0;
      err1_q        <= 1'b0;
    end else begin
      if (accept) begin
        alu_src1_q    <= sel_src1;
        alu_src2_q    <= sel_src2;
        alu_imm_q     <= sel_imm;
        // an illegal code never reaches the ALU so its output stays quiet
        alu_control_q <= legal ? sel_ctrl : '0;
        owner_q       <= sel;
        last_grant_q  <= sel;
        if (!legal) begin
          if (sel) begin
            result1_q <= '0;
            err1_q    <= 1'b1;
          end else begin
            result0_q <= '0;
            err0_q    <= 1'b1;
          end
        end
      end
      if (state_q == EXEC) begin
        if (owner_q) result1_q <= bus.alu_result;
        else         result0_q <= bus.alu_result;
      end
      if (rsp_fire) begin
        err0_q        <= 1'b0;
        err1_q        <= 1'b0;
        alu_control_q <= '0;
      end
    end
  end

  assign bus.req0_ready  = req0_ready;
  assign bus.req1_ready  = req1_ready;
  assign bus.rsp0_valid  = rsp0_valid;
  assign bus.rsp1_valid  = rsp1_valid;
  assign bus.rsp0_result = result0_q;
  assign bus.rsp1_result = result1_q;
  assign bus.rsp0_err    = err0_q;
  assign bus.rsp1_err    = err1_q;
  assign bus.alu_src1    = alu_src1_q;
  assign bus.alu_src2    = alu_src2_q;
  assign bus.alu_imm     = alu_imm_q;
  assign bus.alu_control = alu_control_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: stimulus pushes expected responses
// in expected service order, a monitor pops and compares each handshake.
module tb_alu_share_arbiter;
  localparam int DATA_W = 32;
  localparam int CTRL_W = 6;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  alu_share_arbiter_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

  alu_share_arbiter #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .MAX_OP(6'h11)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference ALU: 01 add, 02 sub, 03 xor, 04 and, 05 or, 11 src1+imm
  always_comb begin
    case (bus.alu_control)
      6'h01:   bus.alu_result = bus.alu_src1 + bus.alu_src2;
      6'h02:   bus.alu_result = bus.alu_src1 - bus.alu_src2;
      6'h03:   bus.alu_result = bus.alu_src1 ^ bus.alu_src2;
      6'h04:   bus.alu_result = bus.alu_src1 & bus.alu_src2;
      6'h05:   bus.alu_result = bus.alu_src1 | bus.alu_src2;
      6'h11:   bus.alu_result = bus.alu_src1 + bus.alu_imm;
      default: bus.alu_result = '0;
    endcase
  end

  typedef struct {
    int                port;
    logic [DATA_W-1:0] res;
    logic              err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rsp_seen = 0;
  int   acc_cyc[2];
  int   first_cyc[2];
  logic pv0 = 1'b0;
  logic pv1 = 1'b0;
  logic [5:0] ill_ctrl [3] = '{6'h00, 6'h3F, 6'h12};
  int   sa[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_exp(input int port, input logic [DATA_W-1:0] res, input logic err);
    exp_t e;
    e.port = port;
    e.res  = res;
    e.err  = err;
    exp_q.push_back(e);
  endfunction

  task automatic check_rsp(input int port, input logic [DATA_W-1:0] res, input logic err);
    exp_t e;
    chk("rsp_expected", exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("rsp_port", port, e.port);
      chk("rsp_result", res, e.res);
      chk("rsp_err", err, e.err);
    end
    rsp_seen++;
  endtask

  // Holds a request until accepted; acc_cyc records the cycle of the accept edge
  task automatic drive_req(input int port, input logic [31:0] s1, input logic [31:0] s2,
                           input logic [31:0] imm, input logic [5:0] ctrl);
    bit got = 1'b0;
    if (port == 0) begin
      bus.req0_src1 = s1; bus.req0_src2 = s2; bus.req0_imm = imm; bus.req0_ctrl = ctrl;
      bus.req0_valid = 1'b1;
    end else begin
      bus.req1_src1 = s1; bus.req1_src2 = s2; bus.req1_imm = imm; bus.req1_ctrl = ctrl;
      bus.req1_valid = 1'b1;
    end
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if ((port == 0) ? bus.req0_ready : bus.req1_ready) begin
        got = 1'b1;
        acc_cyc[port] = cyc;
      end
    end
    chk("accept", got, 1);
    if (got) @(posedge clk);
    #1;
    if (port == 0) bus.req0_valid = 1'b0;
    else           bus.req1_valid = 1'b0;
  endtask

  // Waits (bounded) for every expected response, then steps past the final handshake
  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Response monitor
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      pv0 = 1'b0;
      pv1 = 1'b0;
    end else begin
      if (bus.rsp0_valid && !pv0) first_cyc[0] = cyc;
      if (bus.rsp1_valid && !pv1) first_cyc[1] = cyc;
      pv0 = bus.rsp0_valid;
      pv1 = bus.rsp1_valid;
      chk("rsp_exclusive", bus.rsp0_valid && bus.rsp1_valid, 0);
      if (bus.rsp0_valid && bus.rsp0_ready) check_rsp(0, bus.rsp0_result, bus.rsp0_err);
      if (bus.rsp1_valid && bus.rsp1_ready) check_rsp(1, bus.rsp1_result, bus.rsp1_err);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel;
    int seen;
    bit up;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_src1 = '0; bus.req0_src2 = '0; bus.req0_imm = '0; bus.req0_ctrl = '0;
    bus.req1_src1 = '0; bus.req1_src2 = '0; bus.req1_imm = '0; bus.req1_ctrl = '0;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_req_ready", {bus.req0_ready, bus.req1_ready}, 0);
    chk("rst_rsp_valid", {bus.rsp0_valid, bus.rsp1_valid}, 0);
    chk("rst_rsp_err", {bus.rsp0_err, bus.rsp1_err}, 0);
    chk("rst_rsp0_result", bus.rsp0_result, 0);
    chk("rst_rsp1_result", bus.rsp1_result, 0);
    chk("rst_alu_src1", bus.alu_src1, 0);
    chk("rst_alu_src2", bus.alu_src2, 0);
    chk("rst_alu_imm", bus.alu_imm, 0);
    chk("rst_alu_control", bus.alu_control, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Tie after reset: port 0 first (10-3), then port 1 (F0^0F)
    push_exp(0, 32'd7, 1'b0);
    push_exp(1, 32'hFF, 1'b0);
    fork
      drive_req(0, 32'd10, 32'd3, 32'd0, 6'h02);
      drive_req(1, 32'hF0, 32'h0F, 32'd0, 6'h03);
    join
    wait_idle();
    chk("tie1_gap", acc_cyc[1] - acc_cyc[0], 3);

    // Single add on port 0, latency and operand registers
    push_exp(0, 32'd12, 1'b0);
    drive_req(0, 32'd5, 32'd7, 32'd0, 6'h01);
    chk("add_alu_control", bus.alu_control, 6'h01);
    chk("add_alu_src1", bus.alu_src1, 32'd5);
    chk("add_alu_src2", bus.alu_src2, 32'd7);
    chk("add_rsp0_in_exec", bus.rsp0_valid, 0);
    wait_idle();
    chk("add_latency", first_cyc[0] - acc_cyc[0], 2);
    chk("add_alu_control_quiet", bus.alu_control, 0);

    // Second tie, port 0 granted last: port 1 first (MAX_OP: 100+23), then port 0 (C|3)
    push_exp(1, 32'd123, 1'b0);
    push_exp(0, 32'h0F, 1'b0);
    fork
      drive_req(0, 32'h0C, 32'h03, 32'd0, 6'h05);
      drive_req(1, 32'd100, 32'd0, 32'd23, 6'h11);
    join
    wait_idle();
    chk("tie2_gap", acc_cyc[0] - acc_cyc[1], 3);

    // Back-pressure on port 0 while port 1 waits
    push_exp(0, 32'd3, 1'b0);
    push_exp(1, 32'h0F, 1'b0);
    bus.rsp0_ready = 1'b0;
    rel = 0;
    fork
      drive_req(0, 32'd1, 32'd2, 32'd0, 6'h01);
      begin
        @(posedge clk); #1;
        drive_req(1, 32'hFF, 32'h0F, 32'd0, 6'h04);
      end
      begin
        up = 1'b0;
        for (int i = 0; i < 20 && !up; i++) begin
          @(negedge clk);
          if (bus.rsp0_valid) up = 1'b1;
        end
        chk("bp_rsp0_up", up, 1);
        repeat (5) begin
          @(negedge clk);
          chk("bp_rsp0_valid", bus.rsp0_valid, 1);
          chk("bp_rsp0_result", bus.rsp0_result, 32'd3);
          chk("bp_req1_ready", bus.req1_ready, 0);
          chk("bp_alu_src1", bus.alu_src1, 32'd1);
        end
        @(posedge clk); #1;
        bus.rsp0_ready = 1'b1;
        rel = cyc;
      end
    join
    wait_idle();
    chk("bp_req1_accept", acc_cyc[1], rel + 1);

    // Illegal codes on port 1: zero, all-ones, MAX_OP+1
    for (int k = 0; k < 3; k++) begin
      push_exp(1, 32'd0, 1'b1);
      drive_req(1, 32'hAA + k, 32'hBB, 32'd0, ill_ctrl[k]);
      chk("ill_alu_control", bus.alu_control, 0);
      chk("ill_alu_src1", bus.alu_src1, 32'hAA + k);
      chk("ill_rsp1_valid", bus.rsp1_valid, 1);
      wait_idle();
      chk("ill_latency", first_cyc[1] - acc_cyc[1], 1);
    end

    // Streaming on port 0, including a wrap-around add
    push_exp(0, 32'd2, 1'b0);
    push_exp(0, 32'd4, 1'b0);
    push_exp(0, 32'd30, 1'b0);
    push_exp(0, 32'd0, 1'b0);
    drive_req(0, 32'd1, 32'd1, 32'd0, 6'h01);  sa[0] = acc_cyc[0];
    drive_req(0, 32'd2, 32'd2, 32'd0, 6'h01);  sa[1] = acc_cyc[0];
    drive_req(0, 32'd10, 32'd20, 32'd0, 6'h01); sa[2] = acc_cyc[0];
    drive_req(0, 32'hFFFF_FFFF, 32'd1, 32'd0, 6'h01); sa[3] = acc_cyc[0];
    wait_idle();
    for (int k = 0; k < 3; k++) chk("stream_interval", sa[k+1] - sa[k], 3);

    // Both ports streaming: strict alternation starting with port 1
    push_exp(1, 32'd2, 1'b0);
    push_exp(0, 32'd8, 1'b0);
    push_exp(1, 32'd42, 1'b0);
    push_exp(0, 32'h101, 1'b0);
    fork
      begin
        drive_req(1, 32'd1, 32'd3, 32'd0, 6'h03);
        drive_req(1, 32'd50, 32'd8, 32'd0, 6'h02);
      end
      begin
        drive_req(0, 32'd4, 32'd4, 32'd0, 6'h01);
        drive_req(0, 32'h100, 32'd1, 32'd0, 6'h05);
      end
    join
    wait_idle();

    // Reset while in EXEC: everything clears, nothing is answered
    drive_req(0, 32'h20, 32'h22, 32'd0, 6'h01);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_alu_control", bus.alu_control, 0);
    chk("mid_rst_alu_src1", bus.alu_src1, 0);
    chk("mid_rst_rsp0_valid", bus.rsp0_valid, 0);
    chk("mid_rst_rsp0_result", bus.rsp0_result, 0);
    chk("mid_rst_rsp1_result", bus.rsp1_result, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = rsp_seen;
    repeat (10) @(posedge clk);
    #1;
    chk("no_rsp_after_rst", rsp_seen - seen, 0);
    chk("post_rst_alu_control", bus.alu_control, 0);

    // Tie after the mid-op reset goes to port 0 again
    push_exp(0, 32'd7, 1'b0);
    push_exp(1, 32'd5, 1'b0);
    fork
      drive_req(0, 32'd3, 32'd4, 32'd0, 6'h01);
      drive_req(1, 32'd9, 32'd4, 32'd0, 6'h02);
    join
    wait_idle();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
